id_ex_stage: RTL and testbench

ID/EX pipeline register sitting directly downstream of the register file read ports. It captures decode outputs and register read data into the EX stage. It bypasses same-cycle writeback data, which the register file does not yet reflect because its write occurs at the clock edge. It also detects load-use hazards, inserts bubbles and honours branch flushes.

---
 rtl/id_ex_stage.sv | 131 +++++++++++++
 tb/tb_id_ex_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decode fields and register-file operands,
// bypasses same-cycle writeback data, and inserts bubbles on load-use hazards or flushes.
module id_ex_stage #(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_id,
  input  logic [31:0]       pc_id,
  input  logic [4:0]        rs1_id,
  input  logic [4:0]        rs2_id,
  input  logic              uses_rs1_id,
  input  logic              uses_rs2_id,
  input  logic [4:0]        rd_id,
  input  logic [31:0]       rdata1,
  input  logic [31:0]       rdata2,
  input  logic [31:0]       imm_id,
  input  logic [CTRL_W-1:0] ctrl_id,
  input  logic              RegWrite_id,
  input  logic              MemRead_id,
  input  logic              MemWrite_id,
  input  logic [31:0]       wdata,
  input  logic [4:0]        waddr,
  input  logic              RegWrite_MW,
  input  logic              flush_ex,
  output logic              valid_ex,
  output logic [31:0]       pc_ex,
  output logic [31:0]       imm_ex,
  output logic [4:0]        rs1_ex,
  output logic [4:0]        rs2_ex,
  output logic [4:0]        rd_ex,
  output logic [31:0]       op1_ex,
  output logic [31:0]       op2_ex,
  output logic [CTRL_W-1:0] ctrl_ex,
  output logic              RegWrite_ex,
  output logic              MemRead_ex,
  output logic              MemWrite_ex,
  output logic              stall_if_id,
  output logic [CNT_W-1:0]  stall_count
);

  logic              byp1_s;
  logic              byp2_s;
  logic              haz_s;
  logic              stall_s;
  logic [31:0]       op1_nxt_s;
  logic [31:0]       op2_nxt_s;
  logic [CNT_W-1:0]  cnt_max_s;

  // Writeback bypass and load-use hazard detection
  always_comb begin
    byp1_s    = 1'b0;
    byp2_s    = 1'b0;
    haz_s     = 1'b0;
    stall_s   = 1'b0;
    op1_nxt_s = 32'd0;
    op2_nxt_s = 32'd0;
    cnt_max_s = {CNT_W{1'b1}};

    byp1_s = RegWrite_MW & (waddr != 5'd0) & (waddr == rs1_id);
    byp2_s = RegWrite_MW & (waddr != 5'd0) & (waddr == rs2_id);

    if (byp1_s) begin
      op1_nxt_s = wdata;
    end else begin
      op1_nxt_s = rdata1;
    end

    if (byp2_s) begin
      op2_nxt_s = wdata;
    end else begin
      op2_nxt_s = rdata2;
    end

    haz_s = valid_ex & MemRead_ex & (rd_ex != 5'd0) & valid_id &
            ((uses_rs1_id & (rd_ex == rs1_id)) | (uses_rs2_id & (rd_ex == rs2_id)));
    // A flush kills the dependent instruction anyway, so it must not also stall
    stall_s = haz_s & ~flush_ex;
  end

  assign stall_if_id = stall_s;

  // EX slot register: bubble on flush or stall, otherwise capture decode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_ex    <= 1'b0;
      pc_ex       <= 32'd0;
      imm_ex      <= 32'd0;
      rs1_ex      <= 5'd0;
      rs2_ex      <= 5'd0;
      rd_ex       <= 5'd0;
      op1_ex      <= 32'd0;
      op2_ex      <= 32'd0;
      ctrl_ex     <= {CTRL_W{1'b0}};
      RegWrite_ex <= 1'b0;
      MemRead_ex  <= 1'b0;
      MemWrite_ex <= 1'b0;
    end else if (flush_ex || stall_s) begin
      valid_ex    <= 1'b0;
      RegWrite_ex <= 1'b0;
      MemRead_ex  <= 1'b0;
      MemWrite_ex <= 1'b0;
    end else begin
      valid_ex    <= valid_id;
      pc_ex       <= pc_id;
      imm_ex      <= imm_id;
      rs1_ex      <= rs1_id;
      rs2_ex      <= rs2_id;
      rd_ex       <= rd_id;
      op1_ex      <= op1_nxt_s;
      op2_ex      <= op2_nxt_s;
      ctrl_ex     <= ctrl_id;
      RegWrite_ex <= RegWrite_id & valid_id;
      MemRead_ex  <= MemRead_id & valid_id;
      MemWrite_ex <= MemWrite_id & valid_id;
    end
  end

  // Saturating load-use stall counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_count != cnt_max_s)) begin
      stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_count <= stall_count;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a second instance with CNT_W=3 shares all
// inputs so counter saturation is observable alongside the default-width counter.
module tb_id_ex_stage;

  localparam int CTRL_W = 16;

  logic              clk;
  logic              rst;
  logic              valid_id;
  logic [31:0]       pc_id;
  logic [4:0]        rs1_id, rs2_id, rd_id;
  logic              uses_rs1_id, uses_rs2_id;
  logic [31:0]       rdata1, rdata2, imm_id, wdata;
  logic [CTRL_W-1:0] ctrl_id;
  logic              RegWrite_id, MemRead_id, MemWrite_id;
  logic [4:0]        waddr;
  logic              RegWrite_MW, flush_ex;

  logic              valid_ex, RegWrite_ex, MemRead_ex, MemWrite_ex, stall_if_id;
  logic [31:0]       pc_ex, imm_ex, op1_ex, op2_ex;
  logic [4:0]        rs1_ex, rs2_ex, rd_ex;
  logic [CTRL_W-1:0] ctrl_ex;
  logic [31:0]       stall_count;

  logic              s_valid_ex, s_RegWrite_ex, s_MemRead_ex, s_MemWrite_ex, s_stall_if_id;
  logic [31:0]       s_pc_ex, s_imm_ex, s_op1_ex, s_op2_ex;
  logic [4:0]        s_rs1_ex, s_rs2_ex, s_rd_ex;
  logic [CTRL_W-1:0] s_ctrl_ex;
  logic [2:0]        s_stall_count;

  int n_checks = 0;
  int n_pass   = 0;

  id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .valid_id(valid_id), .pc_id(pc_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id),
    .rd_id(rd_id), .rdata1(rdata1), .rdata2(rdata2), .imm_id(imm_id), .ctrl_id(ctrl_id),
    .RegWrite_id(RegWrite_id), .MemRead_id(MemRead_id), .MemWrite_id(MemWrite_id),
    .wdata(wdata), .waddr(waddr), .RegWrite_MW(RegWrite_MW), .flush_ex(flush_ex),
    .valid_ex(valid_ex), .pc_ex(pc_ex), .imm_ex(imm_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
    .rd_ex(rd_ex), .op1_ex(op1_ex), .op2_ex(op2_ex), .ctrl_ex(ctrl_ex),
    .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex),
    .stall_if_id(stall_if_id), .stall_count(stall_count)
  );

  id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .valid_id(valid_id), .pc_id(pc_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id),
    .rd_id(rd_id), .rdata1(rdata1), .rdata2(rdata2), .imm_id(imm_id), .ctrl_id(ctrl_id),
    .RegWrite_id(RegWrite_id), .MemRead_id(MemRead_id), .MemWrite_id(MemWrite_id),
    .wdata(wdata), .waddr(waddr), .RegWrite_MW(RegWrite_MW), .flush_ex(flush_ex),
    .valid_ex(s_valid_ex), .pc_ex(s_pc_ex), .imm_ex(s_imm_ex), .rs1_ex(s_rs1_ex), .rs2_ex(s_rs2_ex),
    .rd_ex(s_rd_ex), .op1_ex(s_op1_ex), .op2_ex(s_op2_ex), .ctrl_ex(s_ctrl_ex),
    .RegWrite_ex(s_RegWrite_ex), .MemRead_ex(s_MemRead_ex), .MemWrite_ex(s_MemWrite_ex),
    .stall_if_id(s_stall_if_id), .stall_count(s_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Decode slot with no register reads and no control
  task automatic id_plain(input logic [31:0] pc, input logic [4:0] rd);
    valid_id = 1'b1; pc_id = pc; rd_id = rd;
    rs1_id = 5'd1; rs2_id = 5'd2; uses_rs1_id = 1'b0; uses_rs2_id = 1'b0;
    rdata1 = 32'd0; rdata2 = 32'd0; imm_id = 32'd0; ctrl_id = 16'd0;
    RegWrite_id = 1'b1; MemRead_id = 1'b0; MemWrite_id = 1'b0;
  endtask

  initial begin
    rst = 1'b0; flush_ex = 1'b0;
    RegWrite_MW = 1'b0; waddr = 5'd0; wdata = 32'd0;
    id_plain(32'd0, 5'd0);
    valid_id = 1'b0; RegWrite_id = 1'b0;
    step(); step();
    rst = 1'b1;

    // Fill EX so that the asynchronous reset has something to clear
    id_plain(32'h0000_0100, 5'd3);
    imm_id = 32'h0000_1234; ctrl_id = 16'h5A5A;
    #1;
    check("pre_stall", stall_if_id, 1'b0);
    step();
    check("fill_valid", valid_ex, 1'b1);
    check("fill_pc", pc_ex, 32'h100);
    check("fill_imm", imm_ex, 32'h1234);
    check("fill_ctrl", ctrl_ex, 16'h5A5A);
    check("fill_regwr", RegWrite_ex, 1'b1);

    // Mid-cycle asynchronous reset
    #2;
    rst = 1'b0;
    #1;
    check("rst_valid", valid_ex, 1'b0);
    check("rst_pc", pc_ex, 32'd0);
    check("rst_imm", imm_ex, 32'd0);
    check("rst_ctrl", ctrl_ex, 16'd0);
    check("rst_regwr", RegWrite_ex, 1'b0);
    check("rst_cnt", stall_count, 32'd0);
    #1;
    rst = 1'b1;
    step();
    check("post_rst_pc", pc_ex, 32'h100);
    check("post_rst_valid", valid_ex, 1'b1);

    // Bypass rs1 from writeback, rs2 from register file
    id_plain(32'h0000_0104, 5'd4);
    rs1_id = 5'd5; rdata1 = 32'h11; rs2_id = 5'd6; rdata2 = 32'h22;
    RegWrite_MW = 1'b1; waddr = 5'd5; wdata = 32'hAA;
    step();
    check("byp_op1", op1_ex, 32'hAA);
    check("byp_op2", op2_ex, 32'h22);
    check("byp_rs1", rs1_ex, 5'd5);

    // x0 never bypasses
    rs1_id = 5'd0; rdata1 = 32'd0; waddr = 5'd0;
    step();
    check("x0_op1", op1_ex, 32'd0);
    check("x0_op2", op2_ex, 32'h22);

    // Same writeback address on both sources
    rs1_id = 5'd9; rs2_id = 5'd9; rdata1 = 32'h33; rdata2 = 32'h44;
    waddr = 5'd9; wdata = 32'hBEEF;
    step();
    check("both_op1", op1_ex, 32'hBEEF);
    check("both_op2", op2_ex, 32'hBEEF);

    // Writeback disabled: no bypass
    RegWrite_MW = 1'b0;
    step();
    check("nowb_op1", op1_ex, 32'h33);
    check("nowb_op2", op2_ex, 32'h44);

    // Invalid decode slot: fields captured, control zeroed
    valid_id = 1'b0; pc_id = 32'h0000_0108; MemWrite_id = 1'b1;
    step();
    check("inv_valid", valid_ex, 1'b0);
    check("inv_pc", pc_ex, 32'h108);
    check("inv_regwr", RegWrite_ex, 1'b0);
    check("inv_memwr", MemWrite_ex, 1'b0);

    // Load-use hazard
    id_plain(32'h0000_0110, 5'd7);
    MemRead_id = 1'b1;
    step();
    check("ld_memrd", MemRead_ex, 1'b1);
    id_plain(32'h0000_0200, 5'd8);
    rs1_id = 5'd1; uses_rs1_id = 1'b1; rs2_id = 5'd7; uses_rs2_id = 1'b0;
    #1;
    check("lu_nouse_stall", stall_if_id, 1'b0);
    uses_rs2_id = 1'b1;
    #1;
    check("lu_stall", stall_if_id, 1'b1);
    step();
    check("lu_bub_valid", valid_ex, 1'b0);
    check("lu_bub_regwr", RegWrite_ex, 1'b0);
    check("lu_bub_memrd", MemRead_ex, 1'b0);
    check("lu_bub_pc", pc_ex, 32'h110);
    check("lu_cnt", stall_count, 32'd1);
    check("lu_stall_clr", stall_if_id, 1'b0);
    step();
    check("lu_cap_valid", valid_ex, 1'b1);
    check("lu_cap_pc", pc_ex, 32'h200);
    check("lu_cap_rd", rd_ex, 5'd8);

    // Flush beats hazard
    id_plain(32'h0000_0300, 5'd7);
    MemRead_id = 1'b1;
    step();
    id_plain(32'h0000_0304, 5'd8);
    rs2_id = 5'd7; uses_rs2_id = 1'b1; flush_ex = 1'b1;
    #1;
    check("fl_stall", stall_if_id, 1'b0);
    step();
    flush_ex = 1'b0;
    check("fl_valid", valid_ex, 1'b0);
    check("fl_memrd", MemRead_ex, 1'b0);
    check("fl_pc_hold", pc_ex, 32'h300);
    check("fl_cnt", stall_count, 32'd1);

    // Load to x0 never stalls
    id_plain(32'h0000_0400, 5'd0);
    MemRead_id = 1'b1;
    step();
    check("x0ld_memrd", MemRead_ex, 1'b1);
    id_plain(32'h0000_0404, 5'd10);
    rs1_id = 5'd0; uses_rs1_id = 1'b1;
    #1;
    check("x0ld_stall", stall_if_id, 1'b0);
    step();
    check("x0ld_valid", valid_ex, 1'b1);

    // Saturation: a self-dependent load alternates capture/stall, nine stalls in 18 edges
    id_plain(32'h0000_0500, 5'd7);
    MemRead_id = 1'b1; rs1_id = 5'd7; uses_rs1_id = 1'b1;
    for (int i = 0; i < 18; i++) step();
    check("sat_cnt3", s_stall_count, 3'd7);
    check("sat_cnt32", stall_count, 32'd10);
    step(); step();
    check("sat_hold3", s_stall_count, 3'd7);
    check("sat_hold32", stall_count, 32'd11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
